// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: sequential unsigned N x N multiplier.
// A single N-bit ripple-carry adder (chain of FullAdder cells) is reused
// across N shift-and-add iterations under a small FSM. Operands enter on a
// start/busy/done handshake and a 2N-bit product is presented with done.
// Optional feature macro: MULT_ZERO_SKIP_EN (zero operand bypasses RUN).

// One-bit full adder cell used to build the ripple-carry chain.
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Plain sum/carry equations for a single bit position.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

module shift_add_mult_ctrl #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [N-1:0]  mcand;
    logic [N-1:0]  acc;
    logic [N-1:0]  mq;
    logic [CW-1:0] cnt;

    logic [N-1:0]  addend;
    logic [N-1:0]  sum;
    logic [N:0]    carry;
    logic          cout;

    // Partial-product select: add the multiplicand only when the current
    // multiplier bit (LSB of mq) is set.
    always_comb begin
        addend = mq[0] ? mcand : '0;
    end

    assign carry[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_adder
            FullAdder u_fa (
                .a    (acc[gi]),
                .b    (addend[gi]),
                .cin  (carry[gi]),
                .sum  (sum[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    assign cout = carry[N];

    // Handshake outputs decoded from the state register.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // FSM and datapath: load on start, N shift-and-add steps, then publish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= '0;
            acc     <= '0;
            mq      <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= multiplicand;
                        mq    <= multiplier;
                        acc   <= '0;
                        cnt   <= '0;
`ifdef MULT_ZERO_SKIP_EN
                        if ((multiplicand == '0) || (multiplier == '0)) begin
                            state   <= DONE;
                            product <= '0;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    acc <= {cout, sum[N-1:1]};
                    mq  <= {sum[0], mq[N-1:1]};
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST_ITER) begin
                        state <= DONE;
                        // Capture the post-shift value of {acc, mq} directly so
                        // the product is valid in the DONE cycle itself.
                        product <= {cout, sum, mq[N-1:1]};
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench for shift_add_mult_ctrl with N=4 and N=8 instances.
// Stimulus pushes expected products and done-cycle numbers into per-DUT
// queues; a negedge monitor pops and compares whenever done is high.
module tb_shift_add_mult_ctrl;

    typedef struct {
        logic [15:0] prod;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst4, start4, busy4, done4;
    logic [3:0]  mcand4, mplier4;
    logic [7:0]  product4;
    logic        rst8, start8, busy8, done8;
    logic [7:0]  mcand8, mplier8;
    logic [15:0] product8;

    shift_add_mult_ctrl #(.N(4)) dut4 (
        .clk          (clk),
        .rst          (rst4),
        .start        (start4),
        .multiplicand (mcand4),
        .multiplier   (mplier4),
        .busy         (busy4),
        .done         (done4),
        .product      (product4)
    );

    shift_add_mult_ctrl #(.N(8)) dut8 (
        .clk          (clk),
        .rst          (rst8),
        .start        (start8),
        .multiplicand (mcand8),
        .multiplier   (mplier8),
        .busy         (busy8),
        .done         (done8),
        .product      (product8)
    );

    exp_t q4[$];
    exp_t q8[$];
    exp_t m4, m8;
    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    function automatic int lat_of(input int n, input int a, input int b);
`ifdef MULT_ZERO_SKIP_EN
        if (a == 0 || b == 0) return 0;
`endif
        return n;
    endfunction

    // Monitor: compare product and done timing against the scoreboard.
    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            if (q4.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_done4: got done with product %0h expected no done (cycle %0d)", product4, cyc);
            end else begin
                m4 = q4.pop_front();
                check("prod4", 64'(product4), 64'(m4.prod));
                check("done_cyc4", 64'(cyc), 64'(m4.cyc));
            end
        end
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_done8: got done with product %0h expected no done (cycle %0d)", product8, cyc);
            end else begin
                m8 = q8.pop_front();
                check("prod8", 64'(product8), 64'(m8.prod));
                check("done_cyc8", 64'(cyc), 64'(m8.cyc));
            end
        end
    end

    // Single operation on the N=4 instance with busy/hold checks.
    task automatic run4(input int a, input int b, input logic [15:0] expv);
        exp_t e;
        int lat;
        lat = lat_of(4, a, b);
        mcand4 = 4'(a); mplier4 = 4'(b); start4 = 1'b1;
        e.prod = expv; e.cyc = cyc + 1 + lat;
        q4.push_back(e);
        @(negedge clk); start4 = 1'b0;
        for (int i = 0; i < lat; i++) begin
            check("busy4_run", 64'(busy4), 64'd1);
            @(negedge clk);
        end
        check("busy4_done", 64'(busy4), 64'd0);
        @(negedge clk);
        check("hold4", 64'(product4), 64'(expv));
        check("done4_low", 64'(done4), 64'd0);
    endtask

    // Single operation on the N=8 instance with busy/hold checks.
    task automatic run8(input int a, input int b, input logic [15:0] expv);
        exp_t e;
        int lat;
        lat = lat_of(8, a, b);
        mcand8 = 8'(a); mplier8 = 8'(b); start8 = 1'b1;
        e.prod = expv; e.cyc = cyc + 1 + lat;
        q8.push_back(e);
        @(negedge clk); start8 = 1'b0;
        for (int i = 0; i < lat; i++) begin
            check("busy8_run", 64'(busy8), 64'd1);
            @(negedge clk);
        end
        check("busy8_done", 64'(busy8), 64'd0);
        @(negedge clk);
        check("hold8", 64'(product8), 64'(expv));
        check("done8_low", 64'(done8), 64'd0);
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got no completion expected finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int t0;
        int lat;
        rst4 = 1'b1; rst8 = 1'b1; start4 = 1'b0; start8 = 1'b0;
        mcand4 = '0; mplier4 = '0; mcand8 = '0; mplier8 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy4", 64'(busy4), 64'd0);
        check("rst_done4", 64'(done4), 64'd0);
        check("rst_prod4", 64'(product4), 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_done8", 64'(done8), 64'd0);
        check("rst_prod8", 64'(product8), 64'd0);
        rst4 = 1'b0; rst8 = 1'b0;
        @(negedge clk);

        // Basic and max-value multiplies.
        run4(13, 11, 16'h008F);
        run4(15, 15, 16'h00E1);
        check("carry_msb4", 64'(product4[7]), 64'd1);
        run8(255, 255, 16'hFE01);

        // Start while busy: only the first operation completes.
        mcand4 = 4'd3; mplier4 = 4'd5; start4 = 1'b1;
        t0 = cyc + 1;
        e.prod = 16'd15; e.cyc = t0 + 4;
        q4.push_back(e);
        @(negedge clk); start4 = 1'b0;
        @(negedge clk);
        mcand4 = 4'd7; mplier4 = 4'd7; start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        while (cyc < t0 + 4) @(negedge clk);
        start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        check("ignored_start_busy4", 64'(busy4), 64'd0);
        repeat (8) @(negedge clk);
        check("ignored_start_prod4", 64'(product4), 64'd15);
        run4(7, 7, 16'd49);

        // Reset mid-operation on the N=8 instance; no done may follow.
        mcand8 = 8'd200; mplier8 = 8'd100; start8 = 1'b1;
        t0 = cyc + 1;
        @(negedge clk); start8 = 1'b0;
        while (cyc < t0 + 3) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        check("midrst_busy8", 64'(busy8), 64'd0);
        check("midrst_done8", 64'(done8), 64'd0);
        check("midrst_prod8", 64'(product8), 64'd0);
        repeat (12) @(negedge clk);
        check("midrst_idle_busy8", 64'(busy8), 64'd0);
        run8(9, 9, 16'd81);

        // Zero operand.
        run8(0, 77, 16'd0);
        run8(77, 0, 16'd0);
        run4(0, 9, 16'd0);

        // Exhaustive N=4 sweep with start held high.
        start4 = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                lat = lat_of(4, a, b);
                mcand4 = 4'(a); mplier4 = 4'(b);
                e.prod = 16'(a * b); e.cyc = cyc + 1 + lat;
                q4.push_back(e);
                repeat (lat + 2) @(negedge clk);
            end
        end
        start4 = 1'b0;

        for (int i = 0; i < 50 && (q4.size() != 0 || q8.size() != 0); i++) @(negedge clk);
        check("q4_drained", 64'(q4.size()), 64'd0);
        check("q8_drained", 64'(q8.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
